// File: rtl/agnus_audio_dma.sv
// agnus_audio_dma: audio DMA slot allocation and location/pointer registers for four channels.
// Define AGNUS_AUDIO_ADDR21_EN for 2 MB chip RAM addressing; default build addresses 512 KB.
module agnus_audio_dma (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:0]  hpos,
    input  logic        strhor,
    input  logic [3:0]  dmal,
    input  logic [3:0]  dmas,
    input  logic [3:0]  dmaen,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic        dma,
    output logic [20:1] address_out,
    output logic [8:1]  reg_address_out
);
`ifdef AGNUS_AUDIO_ADDR21_EN
    localparam logic [20:1] ADDR_MASK = 20'hF_FFFF;
`else
    localparam logic [20:1] ADDR_MASK = 20'h3_FFFF;
`endif
    logic [20:1] r_lc [4];
    logic [20:1] r_pt [4];
    logic [3:0]  r_req;
    logic [3:0]  r_spc;
    logic [3:0]  w_slot;
    logic [3:0]  w_hit;
    logic [3:0]  w_lch;
    logic [3:0]  w_lcl;
    logic [20:1] w_src [4];

    for (genvar g = 0; g < 4; g++) begin : g_ch
        assign w_slot[g] = hpos == 9'(13 + 2 * g);
        assign w_hit[g]  = w_slot[g] & r_req[g] & dmaen[g];
        assign w_lch[g]  = reg_address_in == 8'(8'h50 + 8 * g);
        assign w_lcl[g]  = reg_address_in == 8'(8'h51 + 8 * g);
        assign w_src[g]  = r_spc[g] ? r_lc[g] : r_pt[g];
    end

    always_comb begin
        dma             = 1'b0;
        address_out     = '0;
        reg_address_out = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (w_hit[i] && !reset) begin
                dma             = 1'b1;
                address_out     = w_src[i];
                reg_address_out = 8'(8'h55 + 8 * i);
            end
        end
    end

    // Slot bookkeeping precedes strhor and register writes so a coincident load lands after the slot
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    r_lc[i] <= '0;
                    r_pt[i] <= '0;
                end
                r_req <= '0;
                r_spc <= '0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (w_hit[i])
                        r_pt[i] <= (w_src[i] + 20'd1) & ADDR_MASK;
                    if (w_slot[i]) begin
                        r_req[i] <= 1'b0;
                        r_spc[i] <= 1'b0;
                    end
                    if (w_lch[i])
                        r_lc[i] <= {data_in[4:0], r_lc[i][15:1]} & ADDR_MASK;
                    if (w_lcl[i])
                        r_lc[i] <= {r_lc[i][20:16], data_in[15:1]};
                end
                if (strhor) begin
                    r_req <= dmal;
                    r_spc <= dmas;
                end
            end
        end
    end
endmodule
